// File: rtl/lock_supervisor.sv
// lock_supervisor
//   Sequencing controller between the keypad decoder and a combination-lock core.
//   Forwards keypad digits to the core, judges the attempt once CODE_LEN digits are in
//   (the core only reports `unlocked`), re-arms the core, holds the door open for a
//   bounded time, counts consecutive failures and enforces a lockout.
//
// Ports
//   clk            clock
//   reset          asynchronous reset, active-high
//   key_valid      one-cycle strobe, key_digit holds a new digit
//   key_digit      digit value 0-9
//   key_clear      one-cycle strobe, abandon the current entry
//   core_unlocked  `unlocked` output of the lock core
//   core_reset     reset to the core (reset or re-arm)
//   core_enter     digit strobe to the core
//   core_digit     digit to the core (pass-through)
//   door_open      high while the door is held open
//   locked_out     high while in lockout
//   attempt_fail   one-cycle pulse when an attempt is rejected
//   fail_count     consecutive failed attempts
module lock_supervisor #(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned OPEN_CYCLES    = 500,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned ENTRY_TIMEOUT  = 2000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           key_valid,
    input  logic [3:0]                     key_digit,
    input  logic                           key_clear,
    input  logic                           core_unlocked,
    output logic                           core_reset,
    output logic                           core_enter,
    output logic [3:0]                     core_digit,
    output logic                           door_open,
    output logic                           locked_out,
    output logic                           attempt_fail,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int unsigned TMaxOl  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                      : LOCKOUT_CYCLES;
    localparam int unsigned TMax    = (TMaxOl > ENTRY_TIMEOUT) ? TMaxOl : ENTRY_TIMEOUT;
    localparam int unsigned TimerW  = $clog2(TMax) + 1;
    localparam int unsigned DigitW  = $clog2(CODE_LEN + 1);
    localparam int unsigned FailW   = $clog2(MAX_FAILS + 1);

    localparam logic [DigitW-1:0] LastDigit = DigitW'(CODE_LEN - 1);
    localparam logic [FailW-1:0]  LastFail  = FailW'(MAX_FAILS - 1);
    localparam logic [TimerW-1:0] OpenLast  = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] LockLast  = TimerW'(LOCKOUT_CYCLES - 1);
    localparam logic [TimerW-1:0] EntryLast = TimerW'(ENTRY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StArm     = 3'd0,
        StEntry   = 3'd1,
        StCheck   = 3'd2,
        StOpen    = 3'd3,
        StLockout = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [DigitW-1:0]   digit_cnt_q, digit_cnt_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [FailW-1:0]    fail_count_q, fail_count_d;

    always_comb begin
        state_d      = state_q;
        digit_cnt_d  = digit_cnt_q;
        timer_d      = timer_q;
        fail_count_d = fail_count_q;

        case (state_q)
            StArm: begin
                digit_cnt_d = '0;
                timer_d     = '0;
                state_d     = StEntry;
            end

            StEntry: begin
                if (key_clear) begin
                    // Clear wins over a simultaneous digit; abandoning is not a failure.
                    state_d = StArm;
                end else if (key_valid) begin
                    digit_cnt_d = digit_cnt_q + 1'b1;
                    timer_d     = '0;
                    if (digit_cnt_q == LastDigit) begin
                        state_d = StCheck;
                    end
                end else if (digit_cnt_q != '0) begin
                    // Timeout only runs once an entry has started.
                    if (timer_q == EntryLast) begin
                        state_d = StArm;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            StCheck: begin
                // The core latched the last digit on the edge into this state.
                if (core_unlocked) begin
                    fail_count_d = '0;
                    timer_d      = '0;
                    state_d      = StOpen;
                end else begin
                    fail_count_d = fail_count_q + 1'b1;
                    if (fail_count_q == LastFail) begin
                        timer_d = '0;
                        state_d = StLockout;
                    end else begin
                        state_d = StArm;
                    end
                end
            end

            StOpen: begin
                if (timer_q == OpenLast) begin
                    state_d = StArm;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StLockout: begin
                if (timer_q == LockLast) begin
                    fail_count_d = '0;
                    state_d      = StArm;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = StArm;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StArm;
            digit_cnt_q  <= '0;
            timer_q      <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            digit_cnt_q  <= digit_cnt_d;
            timer_q      <= timer_d;
            fail_count_q <= fail_count_d;
        end
    end

    // Outputs decode from registered state; reset is ORed in so the core is held
    // in reset immediately, without waiting for a clock edge.
    always_comb begin
        core_reset   = reset | (state_q == StArm);
        core_enter   = key_valid & ~key_clear & (state_q == StEntry);
        core_digit   = key_digit;
        door_open    = (state_q == StOpen);
        locked_out   = (state_q == StLockout);
        attempt_fail = (state_q == StCheck) & ~core_unlocked;
        fail_count   = fail_count_q;
    end

endmodule
